// File: rtl/clb_tile_config_loader_if.sv
// Word-serial bitstream channel feeding one clb_tile configuration loader.
// The master drives data/valid and the slave (loader) answers with ready.
interface clb_tile_config_loader_if #(
  parameter int WORD = 32
);
  logic [WORD-1:0] s_data;
  logic            s_valid;
  logic            s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/clb_tile_config_loader.sv
// Bitstream writer for one clb_tile: assembles words into a shadow image, checks
// the XOR checksum word and commits all conf_* vectors atomically on a match.
module clb_tile_config_loader #(
  parameter int CONF_SB  = 48,
  parameter int CONF_HCB = 104,
  parameter int CONF_VCB = 104,
  parameter int CLBIN    = 32,
  parameter int CARRY    = 1,
  parameter int WORD     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  clb_tile_config_loader_if.slave    s_bus,
  output logic [CONF_SB-1:0]         conf_sb,
  output logic [CONF_HCB-1:0]        conf_hcb,
  output logic [CONF_VCB-1:0]        conf_vcb,
  output logic [2*CLBIN-1:0]         conf_io_type0,
  output logic [CLBIN-1:0]           conf_io_type1,
  output logic [2*CARRY-1:0]         conf_cin_type0,
  output logic [CARRY-1:0]           conf_cin_type1,
  output logic                       cset,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int TOTAL  = CONF_SB + CONF_HCB + CONF_VCB + 3*CLBIN + 3*CARRY;
  localparam int NWORDS = (TOTAL + WORD - 1) / WORD;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int WB     = (WORD > 1) ? $clog2(WORD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  localparam int O_HCB = CONF_SB;
  localparam int O_VCB = O_HCB + CONF_HCB;
  localparam int O_IO0 = O_VCB + CONF_VCB;
  localparam int O_IO1 = O_IO0 + 2*CLBIN;
  localparam int O_CI0 = O_IO1 + CLBIN;
  localparam int O_CI1 = O_CI0 + 2*CARRY;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD-1:0]  xor_q, xor_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] conf_q, conf_d;
  logic             cset_q, cset_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer;

  assign s_bus.s_ready = (state_q == LOAD) || (state_q == CHECK);
  assign xfer          = s_bus.s_valid & s_bus.s_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    shadow_d = shadow_q;
    conf_d   = conf_q;
    cset_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          xor_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          // Only payload bits are stored; pad bits of the last word still feed the checksum.
          for (int i = 0; i < TOTAL; i++) begin
            if (cnt_q == CNT_W'(i / WORD)) shadow_d[i] = s_bus.s_data[WB'(i % WORD)];
          end
          xor_d = xor_q ^ s_bus.s_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (s_bus.s_data == xor_q) begin
            conf_d = shadow_q;
            cset_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xor_q    <= '0;
      shadow_q <= '0;
      conf_q   <= '0;
      cset_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      shadow_q <= shadow_d;
      conf_q   <= conf_d;
      cset_q   <= cset_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign conf_sb        = conf_q[O_HCB-1:0];
  assign conf_hcb       = conf_q[O_VCB-1:O_HCB];
  assign conf_vcb       = conf_q[O_IO0-1:O_VCB];
  assign conf_io_type0  = conf_q[O_IO1-1:O_IO0];
  assign conf_io_type1  = conf_q[O_CI0-1:O_IO1];
  assign conf_cin_type0 = conf_q[O_CI1-1:O_CI0];
  assign conf_cin_type1 = conf_q[TOTAL-1:O_CI1];
  assign cset           = cset_q;
  assign done           = done_q;
  assign err            = err_q;
  assign busy           = (state_q != IDLE);
endmodule
